// File: rtl/bkm_mon_pkg.sv
// Shared constants and helpers for the multi-channel BKM step monitor.
//   PLUS_OFS / MINUS_OFS : bit offsets of the plus/minus flags inside a CSD digit
//   MON_LAT              : input-to-result latency in enabled cycles
//   sat_add()            : add b to a, clamped to max
package bkm_mon_pkg;
  localparam int PLUS_OFS  = 1;
  localparam int MINUS_OFS = 0;
  localparam int MON_LAT   = 2;

  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max}) ? max : s[31:0];
  endfunction
endpackage

// File: rtl/bkm_csd2bin_lane.sv
// One value's CSD-to-binary datapath.
//   S1 registers the plus/minus flag vectors, the illegal-digit count and the
//   expected value; S2 registers the binary result.
// Ports:
//   clk, srst_n : clock, synchronous active-low reset
//   en_i        : advance enable (all state holds when low)
//   csd_i       : 2*WD-bit CSD value, exp_i : expected binary value
//   dif_o       : S1 result (P - N), mism_o : S1 result differs from expected
//   ill_o       : S1 illegal-digit count, res_o : S2 registered result
module bkm_csd2bin_lane #(
  parameter int WD = 64,
  parameter int IW = $clog2(WD + 1)
) (
  input  logic            clk,
  input  logic            srst_n,
  input  logic            en_i,
  input  logic [2*WD-1:0] csd_i,
  input  logic [WD-1:0]   exp_i,
  output logic [WD-1:0]   dif_o,
  output logic            mism_o,
  output logic [IW-1:0]   ill_o,
  output logic [WD-1:0]   res_o
);
  import bkm_mon_pkg::*;

  logic [WD-1:0] p_d, n_d, p_q, n_q, exp_q, res_q;
  logic [IW-1:0] ill_d, ill_q;

  // An illegal digit sets the same bit in P and N, so P - N already treats
  // it as zero; it only needs counting.
  always_comb begin
    p_d   = '0;
    n_d   = '0;
    ill_d = '0;
    for (int i = 0; i < WD; i++) begin
      p_d[i] = csd_i[2*i+PLUS_OFS];
      n_d[i] = csd_i[2*i+MINUS_OFS];
      ill_d  = ill_d + IW'(p_d[i] & n_d[i]);
    end
  end

  assign dif_o  = p_q - n_q;
  assign mism_o = (dif_o != exp_q);
  assign ill_o  = ill_q;
  assign res_o  = res_q;

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      p_q   <= '0;
      n_q   <= '0;
      exp_q <= '0;
      ill_q <= '0;
      res_q <= '0;
    end else if (en_i) begin
      p_q   <= p_d;
      n_q   <= n_d;
      exp_q <= exp_i;
      ill_q <= ill_d;
      res_q <= dif_o;
    end
  end
endmodule

// File: rtl/bkm_step_monitor_mc.sv
// Multi-channel pipelined BKM step monitor: converts NCH CSD X/Y pairs to
// binary, flags mismatches against expected values and keeps saturating
// sample / mismatch / illegal-digit counters.
// Ports:
//   clk, srst_n          : clock, synchronous active-low reset
//   enable, in_valid     : pipeline advance, input sample valid
//   X_np1_csd, Y_np1_csd : CSD inputs, channel c at [c*2*WD +: 2*WD]
//   exp_X, exp_Y, chk_en : expected values and compare enable
//   cnt_clr              : synchronous counter clear (ignores enable)
//   res_X_np1, res_Y_np1 : binary results, res_valid : result valid
//   err_mask             : bit 2c = X mismatch, bit 2c+1 = Y mismatch
//   mism_cnt, illegal_cnt, sample_cnt : saturating counters
// Optional (macro BKM_MON_FIRST_ERR_EN): first_err_valid/idx/sample/res
// capture of the first mismatching result after reset or cnt_clr.
module bkm_step_monitor_mc #(
  parameter int WD  = 64,
  parameter int NCH = 4,
  parameter int CW  = 16
) (
  input  logic                clk,
  input  logic                srst_n,
  input  logic                enable,
  input  logic                in_valid,
  input  logic [NCH*2*WD-1:0] X_np1_csd,
  input  logic [NCH*2*WD-1:0] Y_np1_csd,
  input  logic [NCH*WD-1:0]   exp_X,
  input  logic [NCH*WD-1:0]   exp_Y,
  input  logic                chk_en,
  input  logic                cnt_clr,
  output logic [NCH*WD-1:0]   res_X_np1,
  output logic [NCH*WD-1:0]   res_Y_np1,
  output logic                res_valid,
  output logic [2*NCH-1:0]    err_mask,
  output logic [CW-1:0]       mism_cnt,
  output logic [CW-1:0]       illegal_cnt,
  output logic [CW-1:0]       sample_cnt
`ifdef BKM_MON_FIRST_ERR_EN
  ,
  output logic                first_err_valid,
  output logic [2*NCH-1:0]    first_err_idx,
  output logic [CW-1:0]       first_err_sample,
  output logic [WD-1:0]       first_err_res
`endif
);
  import bkm_mon_pkg::*;

  localparam int          NL   = 2 * NCH;
  localparam int          IW   = $clog2(WD + 1);
  localparam logic [31:0] CMAX = (32'd1 << CW) - 32'd1;

  logic [NL-1:0][2*WD-1:0] csd;
  logic [NL-1:0][WD-1:0]   expv, dif, res;
  logic [NL-1:0][IW-1:0]   ill;
  logic [NL-1:0]           mism, err_d, err_q;
  logic [MON_LAT:1]        vld_pipe_q;
  logic                    chk_q, adv;
  logic [31:0]             ill_sum, mism_sum;
  logic [CW-1:0]           smp_d, smp_q, mis_d, mis_q, ill_d, ill_q;

  // Lane 2c carries X of channel c, lane 2c+1 carries Y.
  always_comb begin
    csd  = '0;
    expv = '0;
    for (int c = 0; c < NCH; c++) begin
      csd[2*c]    = X_np1_csd[c*2*WD +: 2*WD];
      csd[2*c+1]  = Y_np1_csd[c*2*WD +: 2*WD];
      expv[2*c]   = exp_X[c*WD +: WD];
      expv[2*c+1] = exp_Y[c*WD +: WD];
    end
  end

  for (genvar l = 0; l < NL; l++) begin : g_lane
    bkm_csd2bin_lane #(.WD(WD), .IW(IW)) u_lane (
      .clk    (clk),
      .srst_n (srst_n),
      .en_i   (enable),
      .csd_i  (csd[l]),
      .exp_i  (expv[l]),
      .dif_o  (dif[l]),
      .mism_o (mism[l]),
      .ill_o  (ill[l]),
      .res_o  (res[l])
    );
  end

  for (genvar c = 0; c < NCH; c++) begin : g_out
    assign res_X_np1[c*WD +: WD] = res[2*c];
    assign res_Y_np1[c*WD +: WD] = res[2*c+1];
  end

  // S1 holds a valid sample about to land in S2 on this enabled edge.
  assign adv   = enable & vld_pipe_q[1];
  assign err_d = (vld_pipe_q[1] & chk_q) ? mism : '0;

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      vld_pipe_q <= '0;
      chk_q      <= 1'b0;
      err_q      <= '0;
    end else if (enable) begin
      vld_pipe_q <= {vld_pipe_q[MON_LAT-1:1], in_valid};
      chk_q      <= chk_en;
      err_q      <= err_d;
    end
  end

  assign res_valid = vld_pipe_q[MON_LAT];
  assign err_mask  = err_q;

  // Counters advance together with S2, so they already include the result
  // currently presented on the outputs.
  always_comb begin
    ill_sum = '0;
    for (int l = 0; l < NL; l++) ill_sum = ill_sum + 32'(ill[l]);
    mism_sum = 32'($countones(err_d));
    smp_d    = smp_q;
    mis_d    = mis_q;
    ill_d    = ill_q;
    if (cnt_clr) begin
      smp_d = '0;
      mis_d = '0;
      ill_d = '0;
    end else if (adv) begin
      smp_d = CW'(sat_add(32'(smp_q), 32'd1, CMAX));
      mis_d = CW'(sat_add(32'(mis_q), mism_sum, CMAX));
      ill_d = CW'(sat_add(32'(ill_q), ill_sum, CMAX));
    end
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      smp_q <= '0;
      mis_q <= '0;
      ill_q <= '0;
    end else begin
      smp_q <= smp_d;
      mis_q <= mis_d;
      ill_q <= ill_d;
    end
  end

  assign sample_cnt  = smp_q;
  assign mism_cnt    = mis_q;
  assign illegal_cnt = ill_q;

`ifdef BKM_MON_FIRST_ERR_EN
  logic              fe_v_q;
  logic [NL-1:0]     fe_idx_q;
  logic [CW-1:0]     fe_smp_q;
  logic [WD-1:0]     fe_res_q, low_res;

  always_comb begin
    low_res = '0;
    for (int l = NL - 1; l >= 0; l--) if (err_d[l]) low_res = dif[l];
  end

  always_ff @(posedge clk) begin
    if (!srst_n || cnt_clr) begin
      fe_v_q   <= 1'b0;
      fe_idx_q <= '0;
      fe_smp_q <= '0;
      fe_res_q <= '0;
    end else if (adv && |err_d && !fe_v_q) begin
      fe_v_q   <= 1'b1;
      fe_idx_q <= err_d;
      fe_smp_q <= smp_q;
      fe_res_q <= low_res;
    end
  end

  assign first_err_valid  = fe_v_q;
  assign first_err_idx    = fe_idx_q;
  assign first_err_sample = fe_smp_q;
  assign first_err_res    = fe_res_q;
`endif
endmodule

// File: tb/tb_bkm_step_monitor_mc.sv
// Bench for bkm_step_monitor_mc (WD=8, NCH=2, CW=5). A digit-level model
// computes every sample's results; a negedge process compares the DUT with it
// each cycle, and directed literal checks pin the model.
module tb_bkm_step_monitor_mc;
  localparam int WD = 8, NCH = 2, CW = 5, NL = 4, LAT = 2, CMAX = 31;

  logic                clk = 0, srst_n = 0, enable = 1, in_valid = 0, chk_en = 0, cnt_clr = 0;
  logic [NCH*2*WD-1:0] X_np1_csd = '0, Y_np1_csd = '0;
  logic [NCH*WD-1:0]   exp_X = '0, exp_Y = '0;
  logic [NCH*WD-1:0]   res_X_np1, res_Y_np1;
  logic                res_valid;
  logic [2*NCH-1:0]    err_mask;
  logic [CW-1:0]       mism_cnt, illegal_cnt, sample_cnt;
`ifdef BKM_MON_FIRST_ERR_EN
  logic                first_err_valid;
  logic [2*NCH-1:0]    first_err_idx;
  logic [CW-1:0]       first_err_sample;
  logic [WD-1:0]       first_err_res;
`endif

  bkm_step_monitor_mc #(.WD(WD), .NCH(NCH), .CW(CW)) dut (
    .clk(clk), .srst_n(srst_n), .enable(enable), .in_valid(in_valid),
    .X_np1_csd(X_np1_csd), .Y_np1_csd(Y_np1_csd), .exp_X(exp_X), .exp_Y(exp_Y),
    .chk_en(chk_en), .cnt_clr(cnt_clr), .res_X_np1(res_X_np1), .res_Y_np1(res_Y_np1),
    .res_valid(res_valid), .err_mask(err_mask), .mism_cnt(mism_cnt),
    .illegal_cnt(illegal_cnt), .sample_cnt(sample_cnt)
`ifdef BKM_MON_FIRST_ERR_EN
    , .first_err_valid(first_err_valid), .first_err_idx(first_err_idx),
    .first_err_sample(first_err_sample), .first_err_res(first_err_res)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    logic            v;
    logic [3:0][7:0] res;
    logic [3:0]      err;
    int              ill;
  } item_t;

  item_t q[$];
  item_t cur;
  int    m_smp, m_mis, m_ill;
  logic  fe_v;
  logic [3:0] fe_idx;
  int    fe_smp;
  logic [7:0] fe_res;
  bit    started = 0;

  // Value = sum of digit weights, digit = plus - minus, illegal digit = 0.
  function automatic item_t model(input logic v);
    item_t it;
    logic [15:0] c;
    logic [7:0]  e;
    int val;
    it.v = v; it.ill = 0; it.err = '0; it.res = '0;
    for (int l = 0; l < NL; l++) begin
      c = (l % 2 == 0) ? X_np1_csd[(l/2)*16 +: 16] : Y_np1_csd[(l/2)*16 +: 16];
      e = (l % 2 == 0) ? exp_X[(l/2)*8 +: 8] : exp_Y[(l/2)*8 +: 8];
      val = 0;
      for (int i = 0; i < 8; i++) begin
        if (c[2*i+1] && c[2*i]) it.ill++;
        else if (c[2*i+1]) val += (1 << i);
        else if (c[2*i]) val -= (1 << i);
      end
      it.res[l] = val[7:0];
      it.err[l] = chk_en && (it.res[l] != e);
    end
    return it;
  endfunction

  function automatic int sat(input int a, input int b);
    return (a + b > CMAX) ? CMAX : a + b;
  endfunction

  always @(posedge clk) begin
    item_t it;
    if (!srst_n) begin
      q.delete();
      cur.v = 0; cur.err = '0; cur.res = '0; cur.ill = 0;
      m_smp = 0; m_mis = 0; m_ill = 0;
      fe_v = 0; fe_idx = '0; fe_smp = 0; fe_res = '0;
    end else begin
      if (enable) begin
        it = model(in_valid);
        q.push_back(it);
        if (q.size() >= LAT) cur = q.pop_front();
        if (!cnt_clr && cur.v) begin
          if (!fe_v && cur.err != 0) begin
            fe_v = 1; fe_idx = cur.err; fe_smp = m_smp;
            for (int l = NL - 1; l >= 0; l--) if (cur.err[l]) fe_res = cur.res[l];
          end
          m_smp = sat(m_smp, 1);
          m_mis = sat(m_mis, $countones(cur.err));
          m_ill = sat(m_ill, cur.ill);
        end
      end
      if (cnt_clr) begin
        m_smp = 0; m_mis = 0; m_ill = 0;
        fe_v = 0; fe_idx = '0; fe_smp = 0; fe_res = '0;
      end
    end
    started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("res_valid", res_valid, cur.v);
      chk("err_mask", err_mask, cur.v ? cur.err : 4'h0);
      if (cur.v)
        for (int l = 0; l < NL; l++)
          chk("res_lane", (l % 2 == 0) ? res_X_np1[(l/2)*8 +: 8] : res_Y_np1[(l/2)*8 +: 8],
              cur.res[l]);
      chk("sample_cnt", sample_cnt, m_smp);
      chk("mism_cnt", mism_cnt, m_mis);
      chk("illegal_cnt", illegal_cnt, m_ill);
`ifdef BKM_MON_FIRST_ERR_EN
      chk("fe_valid", first_err_valid, fe_v);
      chk("fe_idx", first_err_idx, fe_idx);
      chk("fe_sample", first_err_sample, fe_smp);
      chk("fe_res", first_err_res, fe_res);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Channel 0 gets the given vectors; channel 1 stays zero and matching.
  task automatic put(input logic v, input logic [15:0] x0, input logic [15:0] y0,
                     input logic [7:0] ex0, input logic [7:0] ey0, input logic c);
    in_valid = v; X_np1_csd = {16'h0, x0}; Y_np1_csd = {16'h0, y0};
    exp_X = {8'h0, ex0}; exp_Y = {8'h0, ey0}; chk_en = c;
  endtask

  function automatic logic [15:0] enc(input logic [7:0] v);
    logic [15:0] r = '0;
    for (int i = 0; i < 8; i++) r[2*i+1] = v[i];
    return r;
  endfunction

  task automatic idle();
    put(0, 16'h0, 16'h0, 8'h0, 8'h0, 0);
  endtask

  task automatic clr();
    idle(); cnt_clr = 1; tick(); cnt_clr = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    chk("rst_valid", res_valid, 0);
    chk("rst_sample", sample_cnt, 0);
    chk("rst_err", err_mask, 0);
    srst_n = 1;
    tick();

    // basic conversion: 5 and -3
    put(1, 16'h0022, 16'h0005, 8'h05, 8'hFD, 1); tick(); idle(); tick();
    chk("t1_valid", res_valid, 1);
    chk("t1_resX", res_X_np1[7:0], 8'h05);
    chk("t1_resY", res_Y_np1[7:0], 8'hFD);
    chk("t1_err", err_mask, 0);
    chk("t1_smp", sample_cnt, 1);

    // mismatch on X0, then same with chk_en=0
    put(1, 16'h0021, 16'h0005, 8'h04, 8'hFD, 1); tick(); idle(); tick();
    chk("t2_resX", res_X_np1[7:0], 8'h03);
    chk("t2_err", err_mask, 4'b0001);
    chk("t2_mism", mism_cnt, 1);
    put(1, 16'h0021, 16'h0005, 8'h04, 8'hFD, 0); tick(); idle(); tick();
    chk("t2_err_off", err_mask, 0);
    chk("t2_mism_off", mism_cnt, 1);
    tick();
    chk("t2_bubble", res_valid, 0);

    // illegal digits
    clr();
    chk("clr_smp", sample_cnt, 0);
    put(1, 16'h0003, 16'h0000, 8'h00, 8'h00, 1); tick(); idle(); tick();
    chk("t3_resX", res_X_np1[7:0], 8'h00);
    chk("t3_ill", illegal_cnt, 1);
    put(1, 16'hFFFF, 16'hFFFF, 8'h00, 8'h00, 1); tick(); idle(); tick();
    chk("t3_ill16", illegal_cnt, 17);
    chk("t3_err", err_mask, 0);

    // stall in the middle of a 5-sample stream
    clr();
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        enable = 0;
        put(1, enc(8'h77), 16'h0, 8'h0, 8'h0, 0);
        for (int s = 0; s < 3; s++) begin
          tick();
          chk("stall_valid", res_valid, 1);
          chk("stall_resX", res_X_np1[7:0], 8'h01);
          chk("stall_smp", sample_cnt, 1);
        end
        enable = 1;
      end
      put(1, enc(8'(k + 1)), 16'h0, 8'(k + 1), 8'h0, 1); tick();
    end
    chk("t4_resX", res_X_np1[7:0], 8'h04);
    idle(); tick();
    chk("t4_last", res_X_np1[7:0], 8'h05);
    chk("t4_smp", sample_cnt, 5);
    tick();
    chk("t4_drain", res_valid, 0);

    // saturation of sample_cnt, then clear with a valid result
    clr();
    for (int k = 0; k < 40; k++) begin put(1, enc(8'(k)), enc(8'(3 * k)), 8'h0, 8'h0, 0); tick(); end
    chk("t5_sat", sample_cnt, 31);
    chk("t5_valid", res_valid, 1);
    cnt_clr = 1; tick(); cnt_clr = 0;
    chk("t5_clr_smp", sample_cnt, 0);
    chk("t5_clr_mis", mism_cnt, 0);
    chk("t5_clr_ill", illegal_cnt, 0);
    tick();
    chk("t5_after", sample_cnt, 1);
    // mismatch saturation: all four lanes wrong for 8 samples
    clr();
    for (int k = 0; k < 8; k++) begin
      in_valid = 1; chk_en = 1;
      X_np1_csd = {enc(8'h01), enc(8'h01)}; Y_np1_csd = {enc(8'h01), enc(8'h01)};
      exp_X = '0; exp_Y = '0;
      tick();
    end
    idle(); tick();
    chk("t5_mis_sat", mism_cnt, 31);
    chk("t5_mis_smp", sample_cnt, 8);

    // reset with two samples in flight
    put(1, enc(8'h11), 16'h0, 8'h11, 8'h0, 1); tick(); tick();
    srst_n = 0; tick();
    chk("t6_rst_valid", res_valid, 0);
    chk("t6_rst_smp", sample_cnt, 0);
    chk("t6_rst_mis", mism_cnt, 0);
    srst_n = 1; idle(); tick();
    chk("t6_flush", res_valid, 0);
    tick();
    chk("t6_flush2", res_valid, 0);

    // first-error capture: sample 3 mismatches on Y0, sample 4 on X0
    put(1, enc(8'h01), enc(8'h02), 8'h01, 8'h02, 1); tick();
    put(1, enc(8'h01), enc(8'h02), 8'h01, 8'h02, 1); tick();
    put(1, enc(8'h01), enc(8'h02), 8'h01, 8'h03, 1); tick();
    put(1, enc(8'h05), enc(8'h02), 8'h06, 8'h02, 1); tick();
    idle(); tick(); tick();
    chk("t6_smp", sample_cnt, 4);
    chk("t6_mis", mism_cnt, 2);
`ifdef BKM_MON_FIRST_ERR_EN
    chk("t6_fe_v", first_err_valid, 1);
    chk("t6_fe_smp", first_err_sample, 2);
    chk("t6_fe_idx", first_err_idx, 4'b0010);
    chk("t6_fe_res", first_err_res, 8'h02);
`endif
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
